// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer bundle for sync_fifo_param; parity_err exists only with FIFO_PARITY_EN
interface sync_fifo_param_if #(parameter int DATA_W = 16, parameter int ADDR_W = 4);
  logic              write;
  logic              read;
  logic [DATA_W-1:0] fifo_in;
  logic              err_clr;
  logic [DATA_W-1:0] fifo_out;
  logic              out_valid;
  logic [ADDR_W:0]   fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_half;
  logic              fifo_almost_empty;
  logic              fifo_almost_full;
  logic              overflow;
  logic              underflow;
`ifdef FIFO_PARITY_EN
  logic              parity_err;
  modport master(output write, read, fifo_in, err_clr,
                 input fifo_out, out_valid, fifo_count, fifo_empty, fifo_full, fifo_half,
                 fifo_almost_empty, fifo_almost_full, overflow, underflow, parity_err);
  modport slave(input write, read, fifo_in, err_clr,
                output fifo_out, out_valid, fifo_count, fifo_empty, fifo_full, fifo_half,
                fifo_almost_empty, fifo_almost_full, overflow, underflow, parity_err);
`else
  modport master(output write, read, fifo_in, err_clr,
                 input fifo_out, out_valid, fifo_count, fifo_empty, fifo_full, fifo_half,
                 fifo_almost_empty, fifo_almost_full, overflow, underflow);
  modport slave(input write, read, fifo_in, err_clr,
                output fifo_out, out_valid, fifo_count, fifo_empty, fifo_full, fifo_half,
                fifo_almost_empty, fifo_almost_full, overflow, underflow);
`endif
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with exact count, threshold flags and sticky errors
// FIFO_PARITY_EN stores an even-parity bit per word and flags mismatches on parity_err
module sync_fifo_param #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input logic              clock,
  input logic              reset,
  sync_fifo_param_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] HALF_C  = (ADDR_W+1)'(DEPTH / 2);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);
`ifdef FIFO_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic [MEM_W-1:0]  wr_word, rd_word;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d, ovf_q, ovf_d, udf_q, udf_d;
  logic              empty, full, wr_en, rd_en, bypass;
  // Simultaneous read+write on an empty FIFO bypasses the array; when full, both sides proceed
  always_comb begin
    empty    = count_q == '0;
    full     = count_q == DEPTH_C;
    wr_en    = bus.write && (bus.read ? !empty : !full);
    rd_en    = bus.read && !empty;
    bypass   = bus.read && bus.write && empty;
    rd_word  = mem_q[rd_ptr_q];
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = (wr_en && !rd_en) ? count_q + 1'b1 : (rd_en && !wr_en) ? count_q - 1'b1 : count_q;
    dout_d   = rd_en ? rd_word[DATA_W-1:0] : bypass ? bus.fifo_in : dout_q;
    valid_d  = rd_en || bypass;
    ovf_d    = (bus.write && !bus.read && full) || (ovf_q && !bus.err_clr);
    udf_d    = (bus.read && !bus.write && empty) || (udf_q && !bus.err_clr);
  end
`ifdef FIFO_PARITY_EN
  logic par_q, par_d;
  always_comb begin
    wr_word = {^bus.fifo_in, bus.fifo_in};
    par_d   = (rd_en && ^rd_word) || (par_q && !bus.err_clr);
  end
  always_ff @(posedge clock) par_q <= reset ? 1'b0 : par_d;
  assign bus.parity_err = par_q;
`else
  assign wr_word = bus.fifo_in;
`endif
  always_ff @(posedge clock) if (wr_en) mem_q[wr_ptr_q] <= wr_word;
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end
  assign bus.fifo_out          = dout_q;
  assign bus.out_valid         = valid_q;
  assign bus.fifo_count        = count_q;
  assign bus.fifo_empty        = empty;
  assign bus.fifo_full         = full;
  assign bus.fifo_half         = count_q >= HALF_C;
  assign bus.fifo_almost_empty = count_q <= AE_C;
  assign bus.fifo_almost_full  = count_q >= AF_C;
  assign bus.overflow          = ovf_q;
  assign bus.underflow         = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed checks of sync_fifo_param at default parameters
module tb_sync_fifo_param;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [15:0] q[$];
  logic [15:0] exp_out;
  int   wn;
  bit   up, do_w, do_r;
  sync_fifo_param_if #(.DATA_W(16), .ADDR_W(4)) bus();
  sync_fifo_param dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic drive(input bit w, input bit r, input logic [15:0] d, input bit clr);
    bus.write = w;
    bus.read = r;
    bus.fifo_in = d;
    bus.err_clr = clr;
    tick();
    bus.write = 1'b0;
    bus.read = 1'b0;
    bus.err_clr = 1'b0;
  endtask
  task automatic check_flags(input int c);
    check("count", 32'(bus.fifo_count), 32'(c));
    check("empty", 32'(bus.fifo_empty), 32'(c == 0));
    check("full", 32'(bus.fifo_full), 32'(c == 16));
    check("half", 32'(bus.fifo_half), 32'(c >= 8));
    check("almost_empty", 32'(bus.fifo_almost_empty), 32'(c <= 2));
    check("almost_full", 32'(bus.fifo_almost_full), 32'(c >= 12));
  endtask
  initial begin
    bus.write = 1'b0;
    bus.read = 1'b0;
    bus.fifo_in = '0;
    bus.err_clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_flags(0);
    check("rst_out", 32'(bus.fifo_out), 32'h0);
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_ovf", 32'(bus.overflow), 32'h0);
    check("rst_udf", 32'(bus.underflow), 32'h0);
    for (int i = 1; i <= 16; i++) begin
      drive(1, 0, 16'(i), 0);
      check_flags(i);
      check("fill_ovf", 32'(bus.overflow), 32'h0);
    end
    drive(1, 0, 16'hBEEF, 0);
    check("ovf_set", 32'(bus.overflow), 32'h1);
    check_flags(16);
    for (int i = 1; i <= 16; i++) begin
      drive(0, 1, 16'h0, 0);
      check("drain_out", 32'(bus.fifo_out), 32'(i));
      check("drain_valid", 32'(bus.out_valid), 32'h1);
      check_flags(16 - i);
    end
    tick();
    check("idle_valid", 32'(bus.out_valid), 32'h0);
    drive(0, 1, 16'h0, 0);
    check("udf_set", 32'(bus.underflow), 32'h1);
    check("udf_valid", 32'(bus.out_valid), 32'h0);
    check("udf_hold", 32'(bus.fifo_out), 32'h10);
    check_flags(0);
    drive(0, 0, 16'h0, 1);
    check("udf_clr", 32'(bus.underflow), 32'h0);
    check("ovf_clr", 32'(bus.overflow), 32'h0);
    drive(0, 1, 16'h0, 1);
    check("udf_set_wins", 32'(bus.underflow), 32'h1);
    drive(0, 0, 16'h0, 1);
    check("udf_clr2", 32'(bus.underflow), 32'h0);
    drive(1, 1, 16'h1234, 0);
    check("byp_out", 32'(bus.fifo_out), 32'h1234);
    check("byp_valid", 32'(bus.out_valid), 32'h1);
    check("byp_udf", 32'(bus.underflow), 32'h0);
    check_flags(0);
    for (int i = 0; i < 16; i++) drive(1, 0, 16'h100 + 16'(i), 0);
    drive(1, 1, 16'hAAAA, 0);
    check("rw_full_out", 32'(bus.fifo_out), 32'h100);
    check("rw_full_valid", 32'(bus.out_valid), 32'h1);
    check("rw_full_ovf", 32'(bus.overflow), 32'h0);
    check_flags(16);
    for (int i = 1; i <= 16; i++) begin
      drive(0, 1, 16'h0, 0);
      check("rw_drain", 32'(bus.fifo_out), (i == 16) ? 32'hAAAA : 32'h100 + 32'(i));
    end
    check_flags(0);
    wn = 0;
    up = 1;
    while (wn < 40 || q.size() > 0) begin
      if (wn >= 40) begin do_w = 0; do_r = 1; end
      else if (up) begin do_w = 1; do_r = 0; if (q.size() + 1 == 10) up = 0; end
      else begin do_w = 0; do_r = 1; if (q.size() - 1 == 3) up = 1; end
      if (do_r) exp_out = q.pop_front();
      if (do_w) q.push_back(16'hC000 + 16'(wn * 7));
      drive(do_w, do_r, 16'hC000 + 16'(wn * 7), 0);
      if (do_w) wn++;
      if (do_r) check("mix_out", 32'(bus.fifo_out), 32'(exp_out));
      check("mix_valid", 32'(bus.out_valid), 32'(do_r));
      check_flags(q.size());
    end
    for (int i = 0; i < 9; i++) drive(1, 0, 16'h5A00 + 16'(i), 0);
    drive(0, 1, 16'h0, 0);
    drive(0, 0, 16'h0, 0);
    drive(0, 0, 16'h0, 0);
    for (int i = 0; i < 16; i++) drive(1, 0, 16'h0, 0);
    drive(1, 0, 16'h0, 0);
    check("pre_rst_ovf", 32'(bus.overflow), 32'h1);
    for (int i = 0; i < 7; i++) drive(0, 1, 16'h0, 0);
    check_flags(9);
    reset = 1'b1;
    drive(1, 0, 16'h7777, 0);
    reset = 1'b0;
    check_flags(0);
    check("rst2_out", 32'(bus.fifo_out), 32'h0);
    check("rst2_valid", 32'(bus.out_valid), 32'h0);
    check("rst2_ovf", 32'(bus.overflow), 32'h0);
    drive(0, 1, 16'h0, 0);
    check("rst2_udf", 32'(bus.underflow), 32'h1);
    check("rst2_read_valid", 32'(bus.out_valid), 32'h0);
`ifdef FIFO_PARITY_EN
    drive(0, 0, 16'h0, 1);
    drive(1, 0, 16'h0005, 0);
    dut.mem_q[0][16] = ~dut.mem_q[0][16];
    check("par_idle", 32'(bus.parity_err), 32'h0);
    drive(0, 1, 16'h0, 0);
    check("par_out", 32'(bus.fifo_out), 32'h5);
    check("par_err", 32'(bus.parity_err), 32'h1);
    drive(0, 0, 16'h0, 1);
    check("par_clr", 32'(bus.parity_err), 32'h0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
